// File: rtl/data_memory_p.sv
// Single-port word memory that zero-fills itself after reset, then serves
// reads and writes with range checking and optional registered read data.
module data_memory_p #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned DEPTH        = 256,
    parameter int unsigned READ_LATENCY = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  write_enable,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  busy,
    output logic                  addr_err
);

    localparam int unsigned CNT_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0]    LAST_IDX  = CNT_W'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    // Reject illegal parameterisations at elaboration.
    if (READ_LATENCY > 1) begin : g_bad_latency
        $error("data_memory_p: READ_LATENCY must be 0 or 1");
    end
    if (DATA_WIDTH < 1 || DATA_WIDTH > 64 || ADDR_WIDTH < 1 || ADDR_WIDTH > 16 ||
        DEPTH < 2 || DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_geometry
        $error("data_memory_p: DATA_WIDTH, ADDR_WIDTH or DEPTH out of range");
    end

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [CNT_W-1:0]        clr_cnt;
    logic [CNT_W-1:0]        clr_cnt_nxt;
    logic                    addr_err_nxt;
    logic                    in_range_c;
    logic                    wr_en_c;
    logic [CNT_W-1:0]        wr_idx_c;
    logic [DATA_WIDTH-1:0]   wr_data_c;
    logic [DATA_WIDTH-1:0]   rd_data_c;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // Full-width compare so out-of-range addresses are never folded onto real words.
    assign in_range_c = ({1'b0, address} < DEPTH_EXT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= CLEAR;
            clr_cnt  <= '0;
            addr_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            clr_cnt  <= clr_cnt_nxt;
            addr_err <= addr_err_nxt;
        end
    end

    // Next state plus the single write port shared by reset, clear and user writes.
    always_comb begin
        state_nxt    = state;
        clr_cnt_nxt  = clr_cnt;
        addr_err_nxt = 1'b0;
        wr_en_c      = 1'b0;
        wr_idx_c     = clr_cnt;
        wr_data_c    = '0;
        if (reset) begin
            wr_en_c  = 1'b1;
            wr_idx_c = '0;
        end else begin
            case (state)
                CLEAR: begin
                    wr_en_c  = 1'b1;
                    wr_idx_c = clr_cnt;
                    if (clr_cnt == LAST_IDX) begin
                        state_nxt   = READY;
                        clr_cnt_nxt = '0;
                    end else begin
                        clr_cnt_nxt = clr_cnt + 1'b1;
                    end
                end
                READY: begin
                    addr_err_nxt = !in_range_c;
                    if (write_enable && in_range_c) begin
                        wr_en_c   = 1'b1;
                        wr_idx_c  = address[CNT_W-1:0];
                        wr_data_c = data_in;
                    end
                end
                default: state_nxt = CLEAR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_idx_c] <= wr_data_c;
        end
    end

    assign rd_data_c = (state == READY && in_range_c) ? mem[address[CNT_W-1:0]] : '0;
    assign busy      = (state == CLEAR);

    if (READ_LATENCY == 0) begin : g_comb_read
        assign data_out = rd_data_c;
    end else begin : g_reg_read
        // Read-first: captures the word as it was before this edge's write.
        always_ff @(posedge clk) begin
            if (reset) begin
                data_out <= '0;
            end else begin
                data_out <= rd_data_c;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_p.sv
// Directed bench for data_memory_p: default build, a non-power-of-two depth
// build and a registered-read build, each with hand-computed expectations.
module tb_data_memory_p;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n;

    // Default instance: DEPTH=256, combinational read
    logic       r0, we0, busy0, err0;
    logic [7:0] a0, di0, do0;
    // DEPTH=200 instance
    logic       r1, we1, busy1, err1;
    logic [7:0] a1, di1, do1;
    // Registered-read instance
    logic       r2, we2, busy2, err2;
    logic [7:0] a2, di2, do2;

    data_memory_p u_d0 (
        .clk(clk), .reset(r0), .address(a0), .data_in(di0), .write_enable(we0),
        .data_out(do0), .busy(busy0), .addr_err(err0)
    );

    data_memory_p #(.DEPTH(200)) u_d1 (
        .clk(clk), .reset(r1), .address(a1), .data_in(di1), .write_enable(we1),
        .data_out(do1), .busy(busy1), .addr_err(err1)
    );

    data_memory_p #(.READ_LATENCY(1)) u_d2 (
        .clk(clk), .reset(r2), .address(a2), .data_in(di2), .write_enable(we2),
        .data_out(do2), .busy(busy2), .addr_err(err2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled at the falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        r0 = 1'b0; we0 = 1'b0; a0 = '0; di0 = '0;
        r1 = 1'b0; we1 = 1'b0; a1 = '0; di1 = '0;
        r2 = 1'b0; we2 = 1'b0; a2 = '0; di2 = '0;
        @(negedge clk);

        // ---------------- default instance ----------------
        r0 = 1'b1;
        cyc();
        check("d0_rst_busy", 64'(busy0), 64'd1);
        check("d0_rst_err",  64'(err0),  64'd0);
        check("d0_rst_dout", 64'(do0),   64'd0);
        r0 = 1'b0; we0 = 1'b1; di0 = 8'hFF; a0 = 8'h00;
        n = 1;
        while (n < 1000) begin
            cyc();
            if (!busy0) break;
            n++;
            a0 = 8'(n % 4);
        end
        we0 = 1'b0;
        check("d0_busy_len", 64'(n), 64'd256);
        for (int i = 0; i < 256; i++) begin
            a0 = 8'(i);
            #1 check("d0_clr_rd", 64'(do0), 64'd0);
            cyc();
        end

        a0 = 8'h10; di0 = 8'hA5; we0 = 1'b1;
        #1 check("d0_wr_pre", 64'(do0), 64'd0);
        cyc();
        we0 = 1'b0;
        #1 check("d0_wr_rd", 64'(do0), 64'hA5);
        check("d0_wr_err", 64'(err0), 64'd0);
        a0 = 8'hFF; di0 = 8'h5A; we0 = 1'b1;
        cyc();
        we0 = 1'b0;
        #1 check("d0_top_rd", 64'(do0), 64'h5A);
        a0 = 8'h10;
        #1 check("d0_keep", 64'(do0), 64'hA5);
        @(negedge clk);

        // Reset in the middle of a clear restarts it from word 0
        r0 = 1'b1;
        cyc();
        r0 = 1'b0;
        repeat (99) cyc();
        check("d0_mid_busy", 64'(busy0), 64'd1);
        r0 = 1'b1;
        cyc();
        check("d0_hold_busy1", 64'(busy0), 64'd1);
        cyc();
        check("d0_hold_busy2", 64'(busy0), 64'd1);
        r0 = 1'b0;
        n = 0;
        while (n < 1000) begin
            if (!busy0) break;
            n++;
            cyc();
        end
        check("d0_rst2_len", 64'(n), 64'd256);
        for (int i = 0; i < 256; i++) begin
            a0 = 8'(i);
            #1 check("d0_clr2_rd", 64'(do0), 64'd0);
            cyc();
        end

        // ---------------- DEPTH=200 instance ----------------
        r1 = 1'b1;
        cyc();
        r1 = 1'b0; a1 = 8'hD0; di1 = 8'h3C; we1 = 1'b1;
        cyc();
        check("d1_clr_err",  64'(err1),  64'd0);
        check("d1_clr_busy", 64'(busy1), 64'd1);
        check("d1_clr_dout", 64'(do1),   64'd0);
        n = 0;
        while (busy1 && n < 1000) begin
            cyc();
            n++;
        end
        we1 = 1'b0;
        check("d1_busy_tail", 64'(n), 64'd199);

        we1 = 1'b1;
        a1 = 8'h50; di1 = 8'h77; cyc();
        a1 = 8'h08; di1 = 8'h88; cyc();
        a1 = 8'hC7; di1 = 8'h99; cyc();
        we1 = 1'b0;
        #1 check("d1_last_rd", 64'(do1), 64'h99);
        check("d1_last_err", 64'(err1), 64'd0);
        @(negedge clk);

        a1 = 8'hD0; di1 = 8'h3C; we1 = 1'b1;
        #1 check("d1_oor_rd0", 64'(do1), 64'd0);
        cyc();
        we1 = 1'b0;
        check("d1_oor_err", 64'(err1), 64'd1);
        a1 = 8'h50;
        #1 check("d1_keep50", 64'(do1), 64'h77);
        cyc();
        check("d1_err_clr", 64'(err1), 64'd0);
        a1 = 8'h08;
        #1 check("d1_keep08", 64'(do1), 64'h88);
        a1 = 8'hD0;
        #1 check("d1_oor_rd", 64'(do1), 64'd0);
        @(negedge clk);
        a1 = 8'd200;
        cyc();
        check("d1_err200", 64'(err1), 64'd1);
        a1 = 8'd199;
        cyc();
        check("d1_err199", 64'(err1), 64'd0);

        // ---------------- registered-read instance ----------------
        r2 = 1'b1;
        cyc();
        check("d2_rst_dout", 64'(do2),   64'd0);
        check("d2_rst_busy", 64'(busy2), 64'd1);
        r2 = 1'b0;
        n = 0;
        while (busy2 && n < 1000) begin
            cyc();
            n++;
        end
        check("d2_busy_len", 64'(n), 64'd256);

        a2 = 8'h20; di2 = 8'h11; we2 = 1'b1;
        cyc();
        check("d2_wr_old", 64'(do2), 64'd0);
        a2 = 8'h10; di2 = 8'hA5;
        cyc();
        we2 = 1'b0;
        check("d2_a5_first", 64'(do2), 64'd0);
        cyc();
        check("d2_a5_rd", 64'(do2), 64'hA5);
        a2 = 8'h20;
        cyc();
        check("d2_rd20", 64'(do2), 64'h11);
        we2 = 1'b1; di2 = 8'h22;
        cyc();
        we2 = 1'b0;
        check("d2_rf_old", 64'(do2), 64'h11);
        cyc();
        check("d2_rf_new", 64'(do2), 64'h22);
        r2 = 1'b1;
        cyc();
        r2 = 1'b0;
        check("d2_rst2_dout", 64'(do2), 64'd0);
        check("d2_rst2_err",  64'(err2), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
